frame_bank_scheduler: RTL

- Sequences the shared two-bank frame buffer between the OV7670 capture writer and the ILI9341 display reader.
- After reset, discards a programmable number of camera warm-up frames before any capture.
- Then runs ping-pong: the camera always writes a bank the LCD is not reading, and the LCD always reads the newest complete frame.
- Sits between the camera sync decoder (frame start/end pulses) and the SDRAM/SRAM write/read address generators. Single clock domain.

---
 rtl/frame_bank_scheduler.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/frame_bank_scheduler.sv
// Two-bank frame buffer scheduler between the camera capture writer and the
// display reader. It skips warm-up frames after reset and then ping-pongs the
// writer across the banks while the reader always gets the newest complete frame.
module frame_bank_scheduler #(
  parameter int unsigned SKIP_FRAMES = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             irst_n,
  input  logic             cam_frame_start,
  input  logic             cam_frame_end,
  input  logic             cap_en,
  input  logic             lcd_req,
  input  logic             lcd_done,
  output logic             warmup_done,
  output logic             wr_en,
  output logic             wr_bank,
  output logic             rd_grant,
  output logic             rd_bank,
  output logic [CNT_W-1:0] overwrite_cnt,
  output logic             sync_err
);

  // One spare bit keeps the width non-zero when SKIP_FRAMES is 0.
  localparam int unsigned    WarmW      = $clog2(SKIP_FRAMES + 1) + 1;
  localparam logic [WarmW-1:0] WarmTarget = WarmW'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    BkFree,
    BkWriting,
    BkReady,
    BkReading
  } bank_st_e;

  bank_st_e             bank_q [2];
  bank_st_e             bank_d [2];
  logic                 newest_q, newest_d;
  logic [WarmW-1:0]     warm_cnt_q, warm_cnt_d;
  logic                 warmup_done_q, warmup_done_d;
  logic                 wr_en_q, wr_en_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_grant_q, rd_grant_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]     ovw_cnt_q, ovw_cnt_d;
  logic                 sync_err_q, sync_err_d;

  // Decoded view of the registered bank state.
  logic       writing_q;
  logic       wr_idx;
  logic [1:0] free_q;
  logic [1:0] ready_q;
  logic       end_fire;
  logic       gnt_fire;
  logic       gnt_idx;
  logic [1:0] ready_after;
  logic [1:0] cand;
  logic       newest_after;
  logic       pick_found;
  logic       pick_idx;
  logic       pick_ovw;

  // Decode bank states and the event qualifiers for this cycle.
  always_comb begin
    free_q[0]  = (bank_q[0] == BkFree);
    free_q[1]  = (bank_q[1] == BkFree);
    ready_q[0] = (bank_q[0] == BkReady);
    ready_q[1] = (bank_q[1] == BkReady);
    writing_q  = (bank_q[0] == BkWriting) || (bank_q[1] == BkWriting);
    wr_idx     = (bank_q[1] == BkWriting);

    end_fire = cam_frame_end && writing_q;

    // Reader takes the newest READY bank; fall back to the other one when the
    // newest pointer no longer names a READY bank.
    gnt_fire = lcd_req && !rd_grant_q && (ready_q != 2'b00);
    gnt_idx  = ready_q[newest_q] ? newest_q : ~newest_q;

    // READY candidates for overwrite, seen after this cycle's frame end, minus
    // any bank the reader is being granted right now.
    ready_after[0] = ready_q[0] || (end_fire && !wr_idx);
    ready_after[1] = ready_q[1] || (end_fire && wr_idx);
    cand[0]        = ready_after[0] && !(gnt_fire && !gnt_idx);
    cand[1]        = ready_after[1] && !(gnt_fire && gnt_idx);
    newest_after   = end_fire ? wr_idx : newest_q;
  end

  // Writer bank choice: FREE lowest index first, else the oldest unread READY bank.
  // A bank released by lcd_done this cycle is still READING in bank_q, so it is skipped.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 1'b0;
    pick_ovw   = 1'b0;
    if (free_q[0]) begin
      pick_found = 1'b1;
      pick_idx   = 1'b0;
    end else if (free_q[1]) begin
      pick_found = 1'b1;
      pick_idx   = 1'b1;
    end else if (cand[0] && cand[1]) begin
      pick_found = 1'b1;
      pick_idx   = ~newest_after;
      pick_ovw   = 1'b1;
    end else if (cand[0]) begin
      pick_found = 1'b1;
      pick_idx   = 1'b0;
      pick_ovw   = 1'b1;
    end else if (cand[1]) begin
      pick_found = 1'b1;
      pick_idx   = 1'b1;
      pick_ovw   = 1'b1;
    end
  end

  // Warm-up counter: counts frame ends until the skip target is reached.
  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (cam_frame_end && !warmup_done_q && (warm_cnt_q != WarmTarget)) begin
      warm_cnt_d = warm_cnt_q + 1'b1;
    end
    warmup_done_d = warmup_done_q || (warm_cnt_d == WarmTarget);
  end

  // Next-state for banks, pointers and registered outputs.
  always_comb begin
    bank_d[0]  = bank_q[0];
    bank_d[1]  = bank_q[1];
    newest_d   = newest_q;
    wr_en_d    = wr_en_q;
    wr_bank_d  = wr_bank_q;
    rd_grant_d = rd_grant_q;
    rd_bank_d  = rd_bank_q;
    ovw_cnt_d  = ovw_cnt_q;
    sync_err_d = sync_err_q;

    // Read end releases the granted bank.
    if (lcd_done && rd_grant_q) begin
      bank_d[rd_bank_q] = BkFree;
      rd_grant_d        = 1'b0;
    end

    // Read grant uses pre-cycle READY banks only.
    if (gnt_fire) begin
      bank_d[gnt_idx] = BkReading;
      rd_grant_d      = 1'b1;
      rd_bank_d       = gnt_idx;
    end

    // Capture end is handled before any capture start in the same cycle.
    if (end_fire) begin
      bank_d[wr_idx] = BkReady;
      newest_d       = wr_idx;
      wr_en_d        = 1'b0;
    end

    if (cam_frame_start && warmup_done_q) begin
      if (writing_q && !end_fire) begin
        // Start without end: restart the same bank and flag the sync error.
        sync_err_d = 1'b1;
      end else if (cap_en && pick_found) begin
        bank_d[pick_idx] = BkWriting;
        wr_en_d          = 1'b1;
        wr_bank_d        = pick_idx;
        if (pick_ovw && (ovw_cnt_q != {CNT_W{1'b1}})) begin
          ovw_cnt_d = ovw_cnt_q + 1'b1;
        end
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      bank_q[0]     <= BkFree;
      bank_q[1]     <= BkFree;
      newest_q      <= 1'b0;
      warm_cnt_q    <= '0;
      warmup_done_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      rd_grant_q    <= 1'b0;
      rd_bank_q     <= 1'b0;
      ovw_cnt_q     <= '0;
      sync_err_q    <= 1'b0;
    end else begin
      bank_q[0]     <= bank_d[0];
      bank_q[1]     <= bank_d[1];
      newest_q      <= newest_d;
      warm_cnt_q    <= warm_cnt_d;
      warmup_done_q <= warmup_done_d;
      wr_en_q       <= wr_en_d;
      wr_bank_q     <= wr_bank_d;
      rd_grant_q    <= rd_grant_d;
      rd_bank_q     <= rd_bank_d;
      ovw_cnt_q     <= ovw_cnt_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign warmup_done   = warmup_done_q;
  assign wr_en         = wr_en_q;
  assign wr_bank       = wr_bank_q;
  assign rd_grant      = rd_grant_q;
  assign rd_bank       = rd_bank_q;
  assign overwrite_cnt = ovw_cnt_q;
  assign sync_err      = sync_err_q;

  // Structural invariants of the bank ownership scheme.
  a_one_writer : assert property (@(posedge clk) disable iff (!irst_n)
    !((bank_q[0] == BkWriting) && (bank_q[1] == BkWriting)));
  a_one_reader : assert property (@(posedge clk) disable iff (!irst_n)
    !((bank_q[0] == BkReading) && (bank_q[1] == BkReading)));
  a_rd_owned : assert property (@(posedge clk) disable iff (!irst_n)
    rd_grant_q |-> (bank_q[rd_bank_q] == BkReading));
  a_wr_owned : assert property (@(posedge clk) disable iff (!irst_n)
    wr_en_q |-> (bank_q[wr_bank_q] == BkWriting));

endmodule
